// File: rtl/hist_threshold_scan_ctrl.sv
// Downward threshold search over a signed histogram held in external RAM.
// The histogram is fetched one chunk at a time, starting at the top chunk.
// The search stops at the first chunk holding a positive bin, and the highest
// positive slot in that chunk gives the threshold.
module hist_threshold_scan_ctrl #(
  parameter int         NUM_BINS        = 256,
  parameter int         CHUNK           = 8,
  parameter int         BIN_W           = 17,
  parameter logic [7:0] NOTFOUND_THRESH = 8'd0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_found,
  output logic [7:0]       o_threshold,
  output logic             o_rd_en,
  output logic [7:0]       o_rd_addr,
  input  logic [BIN_W-1:0] i_rd_data
);

  localparam int            KW         = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam logic [7:0]    BASE_TOP   = 8'(NUM_BINS - CHUNK);
  localparam logic [7:0]    CHUNK_STEP = 8'(CHUNK);
  localparam logic [KW-1:0] K_LAST     = KW'(CHUNK - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_EVAL,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       base_q, base_d;
  logic [KW-1:0]    k_q, k_d;
  logic             found_q, found_d;
  logic [7:0]       thresh_q, thresh_d;
  logic [BIN_W-1:0] chunk_q [CHUNK];

  logic             capEn;
  logic [KW-1:0]    capSlot;
  logic             hit;
  logic [KW-1:0]    hitIdx;

  // Priority scan of the registered chunk; the last match is the highest slot
  always_comb begin
    hit    = 1'b0;
    hitIdx = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (!chunk_q[i][BIN_W-1] && (|chunk_q[i])) begin
        hit    = 1'b1;
        hitIdx = KW'(i);
      end
    end
  end

  // RAM data arrives one cycle after its strobe, so it lands in slot k-1
  always_comb begin
    capEn   = 1'b0;
    capSlot = '0;
    if (state_q == ST_READ && k_q != '0) begin
      capEn   = 1'b1;
      capSlot = k_q - 1'b1;
    end else if (state_q == ST_WAIT) begin
      capEn   = 1'b1;
      capSlot = K_LAST;
    end
  end

  // Chunk holding register filled from the RAM return path
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < CHUNK; i++) chunk_q[i] <= '0;
    end else if (capEn) begin
      chunk_q[capSlot] <= i_rd_data;
    end
  end

  // Next-state and result logic; abort takes priority over start and scanning
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    k_d      = k_q;
    found_d  = found_q;
    thresh_d = thresh_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          base_d   = BASE_TOP;
          k_d      = '0;
          found_d  = 1'b0;
          thresh_d = 8'd0;
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (k_q == K_LAST) begin
          state_d = ST_WAIT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_WAIT: begin
        state_d = i_abort ? ST_IDLE : ST_EVAL;
      end
      ST_EVAL: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          thresh_d = base_q + 8'(hitIdx);
          found_d  = 1'b1;
          state_d  = ST_DONE;
        end else if (base_q == 8'd0) begin
          thresh_d = NOTFOUND_THRESH;
          found_d  = 1'b0;
          state_d  = ST_DONE;
        end else begin
          base_d  = base_q - CHUNK_STEP;
          k_d     = '0;
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, chunk base, slot counter and held result registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      base_q   <= BASE_TOP;
      k_q      <= '0;
      found_q  <= 1'b0;
      thresh_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      k_q      <= k_d;
      found_q  <= found_d;
      thresh_q <= thresh_d;
    end
  end

  // Outputs decoded from state so reset clears them without a clock edge
  always_comb begin
    o_busy      = (state_q == ST_READ) || (state_q == ST_WAIT) || (state_q == ST_EVAL);
    o_done      = (state_q == ST_DONE);
    o_rd_en     = (state_q == ST_READ);
    o_rd_addr   = (state_q == ST_READ) ? (base_q + 8'(k_q)) : 8'd0;
    o_found     = found_q;
    o_threshold = thresh_q;
  end

endmodule

// File: tb/tb_hist_threshold_scan_ctrl.sv
// Scoreboard bench for hist_threshold_scan_ctrl: expected read addresses and
// results are queued when a scan is started and popped as the DUT produces them.
module tb_hist_threshold_scan_ctrl;

  typedef struct {
    logic       found;
    logic [7:0] thresh;
    int         cycle;
  } result_t;

  logic        clk;
  logic        rstN;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        found;
  logic [7:0]  threshold;
  logic        rdEn;
  logic [7:0]  rdAddr;
  logic [16:0] rdData;

  logic [16:0] mem [256];

  int      checkCnt = 0;
  int      failCnt  = 0;
  int      edgeCnt  = 0;
  int      acceptCnt = 0;
  int      expAddrQ [$];
  result_t expResQ [$];

  hist_threshold_scan_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_start     (start),
    .i_abort     (abort),
    .o_busy      (busy),
    .o_done      (done),
    .o_found     (found),
    .o_threshold (threshold),
    .o_rd_en     (rdEn),
    .o_rd_addr   (rdAddr),
    .i_rd_data   (rdData)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to measure latency from the accepting edge
  always @(posedge clk) edgeCnt = edgeCnt + 1;

  // Single-port RAM model with one cycle of read latency
  always @(posedge clk) begin
    if (rdEn) rdData <= mem[rdAddr];
  end

  // Watchdog so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCnt = checkCnt + 1;
    if (observed !== expected) begin
      failCnt = failCnt + 1;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Monitor: every read and every done pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (rdEn) begin
      if (expAddrQ.size() == 0) begin
        checkOutput("unexpectedRead", int'(rdAddr), -1);
      end else begin
        checkOutput("readAddr", int'(rdAddr), expAddrQ.pop_front());
      end
      checkOutput("busyDuringRead", int'(busy), 1);
    end
    if (done) begin
      if (expResQ.size() == 0) begin
        checkOutput("unexpectedDone", 1, 0);
      end else begin
        result_t r;
        r = expResQ.pop_front();
        checkOutput("doneCycle", edgeCnt - acceptCnt, r.cycle);
        checkOutput("found", int'(found), int'(r.found));
        checkOutput("threshold", int'(threshold), int'(r.thresh));
        checkOutput("busyInDone", int'(busy), 0);
      end
    end
  end

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 17'h0;
  endtask

  // Model the scan, queue expectations, then pulse start (call #1 after an edge)
  task automatic applyStimulus(input bit withResult, input int chunkLimit);
    int      top;
    int      chunks;
    bit      fnd;
    result_t r;
    top = -1;
    for (int i = 255; i >= 0; i--) begin
      if ($signed(mem[i]) > 0) begin
        top = i;
        break;
      end
    end
    fnd    = (top >= 0);
    chunks = fnd ? ((255 - top) / 8 + 1) : 32;
    if (chunkLimit > 0 && chunkLimit < chunks) chunks = chunkLimit;
    for (int c = 0; c < chunks; c++) begin
      for (int s = 0; s < 8; s++) expAddrQ.push_back(248 - 8 * c + s);
    end
    if (withResult) begin
      r.found  = fnd;
      r.thresh = fnd ? top[7:0] : 8'd0;
      r.cycle  = 10 * chunks + 1;
      expResQ.push_back(r);
    end
    start     = 1'b1;
    acceptCnt = edgeCnt;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Bounded wait for all queued results, then confirm nothing is left over
  task automatic waitScan(input string tag, input int budget);
    for (int n = 0; n < budget && expResQ.size() != 0; n++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    checkOutput({tag, "_timeout"}, expResQ.size(), 0);
    checkOutput({tag, "_readsLeft"}, expAddrQ.size(), 0);
  endtask

  initial begin
    start  = 1'b0;
    abort  = 1'b0;
    rstN   = 1'b0;
    clearMem();
    #12;
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstDone", int'(done), 0);
    checkOutput("rstFound", int'(found), 0);
    checkOutput("rstThresh", int'(threshold), 0);
    checkOutput("rstRdEn", int'(rdEn), 0);
    checkOutput("rstRdAddr", int'(rdAddr), 0);
    @(posedge clk);
    #1 rstN = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] all-zero histogram, worst case");
    applyStimulus(1'b1, 0);
    waitScan("allZero", 400);

    $display("[TB] bin200 positive, bin203 = -1");
    clearMem();
    mem[200] = 17'd5;
    mem[203] = 17'h1FFFF;
    applyStimulus(1'b1, 0);
    waitScan("bin200", 400);

    $display("[TB] bin255 and bin0 positive, best case");
    clearMem();
    mem[255] = 17'd1;
    mem[0]   = 17'd1;
    applyStimulus(1'b1, 0);
    waitScan("bin255", 400);

    $display("[TB] bins 16/17/23 positive, bin22 most negative");
    clearMem();
    mem[16] = 17'd1;
    mem[17] = 17'd1;
    mem[23] = 17'd1;
    mem[22] = 17'h10000;
    applyStimulus(1'b1, 0);
    waitScan("bin23", 400);

    $display("[TB] only bin16 positive");
    clearMem();
    mem[16] = 17'd1;
    applyStimulus(1'b1, 0);
    @(negedge clk);
    checkOutput("foundClearedOnStart", int'(found), 0);
    checkOutput("threshClearedOnStart", int'(threshold), 0);
    waitScan("bin16", 400);

    $display("[TB] abort during cycle 40");
    clearMem();
    applyStimulus(1'b0, 4);
    repeat (39) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    checkOutput("abortBusy", int'(busy), 0);
    checkOutput("abortRdEn", int'(rdEn), 0);
    checkOutput("abortFound", int'(found), 0);
    waitScan("abort", 20);

    $display("[TB] abort together with start in idle");
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abortBeatsStart", int'(busy), 0);

    $display("[TB] scan after abort, with extra starts at cycles 5 and 11");
    clearMem();
    mem[255] = 17'd1;
    applyStimulus(1'b1, 0);
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitScan("extraStarts", 40);

    $display("[TB] asynchronous reset at cycle 30 of a worst-case scan");
    clearMem();
    applyStimulus(1'b1, 0);
    repeat (29) @(posedge clk);
    #3 rstN = 1'b0;
    #1;
    checkOutput("midRstBusy", int'(busy), 0);
    checkOutput("midRstRdEn", int'(rdEn), 0);
    checkOutput("midRstRdAddr", int'(rdAddr), 0);
    checkOutput("midRstDone", int'(done), 0);
    checkOutput("midRstFound", int'(found), 0);
    checkOutput("midRstThresh", int'(threshold), 0);
    expAddrQ.delete();
    expResQ.delete();
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    @(posedge clk);
    #1;
    mem[255] = 17'd1;
    applyStimulus(1'b1, 0);
    waitScan("afterReset", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCnt, failCnt);
    $finish;
  end

endmodule
